// File: rtl/dma_bus_system_pkg.sv
// Shared widths, bus polarities, DMAC state encoding and address map for dma_bus_system.
package dma_bus_system_pkg;

    localparam int BUS_ADDR_WIDTH = 10;
    localparam int DATA_WIDTH     = 8;
    localparam int BURST_LEN      = 4;
    localparam int LEN_W          = $clog2(BURST_LEN + 1);

    localparam logic Enable_  = 1'b0;
    localparam logic Disable_ = 1'b1;
    localparam logic Read     = 1'b1;
    localparam logic Write    = 1'b0;

    localparam logic [1:0] DMAC_MODE_SINGLE = 2'd0;
    localparam logic [1:0] DMAC_MODE_BURST  = 2'd1;

    typedef enum logic [1:0] {
        DMAC_IDLE  = 2'd0,
        DMAC_READ  = 2'd1,
        DMAC_WRITE = 2'd2,
        DMAC_EOP   = 2'd3
    } dmac_state_e;

    // Region is addr[9:8]; offsets are addr[7:0]
    localparam logic [1:0] REGION_RAM0  = 2'b00;
    localparam logic [1:0] REGION_RAM1  = 2'b01;
    localparam logic [1:0] REGION_TIMER = 2'b10;
    localparam logic [1:0] REGION_NONE  = 2'b11;

    localparam logic [7:0] TMR_COUNT_OFS = 8'h00;
    localparam logic [7:0] TMR_CTRL_OFS  = 8'h04;
    localparam int TMR_CLR_BIT   = 0;
    localparam int TMR_START_BIT = 1;
    localparam int TMR_STOP_BIT  = 2;

    // Modes 2 and 3 fall back to a single-byte transfer
    function automatic logic [LEN_W-1:0] dmac_len(input logic [1:0] mode);
        return (mode == DMAC_MODE_BURST) ? LEN_W'(BURST_LEN) : LEN_W'(1);
    endfunction

endpackage

// File: rtl/dma_bus_system_dmac.sv
// Single-channel memory-to-memory DMA engine: one READ/WRITE pair per byte, then a one-cycle EOP.
module dma_bus_system_dmac
    import dma_bus_system_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_,
    input  logic                      dreq_n_i,
    input  logic                      breq_n_i,
    input  logic [BUS_ADDR_WIDTH-1:0] dsaddr_i,
    input  logic [BUS_ADDR_WIDTH-1:0] ddaddr_i,
    input  logic [1:0]                dmode_i,
    input  logic [DATA_WIDTH-1:0]     rdata_i,
    output dmac_state_e               state_o,
    output logic                      busy_o,
    output logic [BUS_ADDR_WIDTH-1:0] addr_o,
    output logic                      rw_o,
    output logic [DATA_WIDTH-1:0]     wdata_o,
    output logic                      eop_n_o
);

    dmac_state_e               state_q, state_d;
    logic [BUS_ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]     hold_q, hold_d;

    always_ff @(posedge clk) begin
        if (reset_) begin
            state_q <= DMAC_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            DMAC_IDLE: begin
                // The external master has priority: only start when it is not requesting
                if (dreq_n_i == Enable_ && breq_n_i == Disable_) begin
                    src_d   = dsaddr_i;
                    dst_d   = ddaddr_i;
                    cnt_d   = dmac_len(dmode_i);
                    state_d = DMAC_READ;
                end
            end
            DMAC_READ: begin
                hold_d  = rdata_i;
                state_d = DMAC_WRITE;
            end
            DMAC_WRITE: begin
                src_d   = src_q + 1'b1;
                dst_d   = dst_q + 1'b1;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == LEN_W'(1)) ? DMAC_EOP : DMAC_READ;
            end
            default: state_d = DMAC_IDLE;
        endcase
    end

    always_comb begin
        state_o = state_q;
        busy_o  = (state_q == DMAC_READ) || (state_q == DMAC_WRITE);
        addr_o  = (state_q == DMAC_READ) ? src_q : dst_q;
        rw_o    = (state_q == DMAC_WRITE) ? Write : Read;
        wdata_o = hold_q;
        eop_n_o = (state_q == DMAC_EOP) ? Enable_ : Disable_;
    end

endmodule

// File: rtl/dma_bus_system.sv
// 8-bit microsystem: arbiter/decoder, two 256x8 RAMs, free-running timer and a DMAC
// sharing one 10-bit bus between the external master and the DMA engine.
module dma_bus_system
    import dma_bus_system_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_,
    input  logic [BUS_ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]     idata,
    output logic [DATA_WIDTH-1:0]     odata,
    input  logic                      rw_,
    input  logic                      breq_,
    output logic                      bgrt_,
    input  logic [BUS_ADDR_WIDTH-1:0] dsaddr,
    input  logic [BUS_ADDR_WIDTH-1:0] ddaddr,
    input  logic [1:0]                dmode,
    input  logic                      dreq_,
    output logic                      eop_
);

    dmac_state_e               dmac_state;
    logic                      dmac_own, dmac_rw;
    logic [BUS_ADDR_WIDTH-1:0] dmac_addr;
    logic [DATA_WIDTH-1:0]     dmac_wdata;

    logic                      ext_own, bus_vld, bus_rw, bus_we;
    logic [BUS_ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0]     bus_wdata, bus_rdata;
    logic [7:0]                ofs;
    logic                      cs0_, cs1_, cs2_;

    logic [DATA_WIDTH-1:0]     ram0_q [256];
    logic [DATA_WIDTH-1:0]     ram1_q [256];
    logic [DATA_WIDTH-1:0]     count_q, count_d;
    logic                      run_q, run_d, tmr_wr;

    dma_bus_system_dmac u_dmac (
        .clk      (clk),
        .reset_   (reset_),
        .dreq_n_i (dreq_),
        .breq_n_i (breq_),
        .dsaddr_i (dsaddr),
        .ddaddr_i (ddaddr),
        .dmode_i  (dmode),
        .rdata_i  (bus_rdata),
        .state_o  (dmac_state),
        .busy_o   (dmac_own),
        .addr_o   (dmac_addr),
        .rw_o     (dmac_rw),
        .wdata_o  (dmac_wdata),
        .eop_n_o  (eop_)
    );

    // Grant only while the DMAC is idle; a started transfer keeps the bus through EOP
    assign ext_own = (breq_ == Enable_) && (dmac_state == DMAC_IDLE);
    assign bgrt_   = ext_own ? Enable_ : Disable_;

    always_comb begin
        bus_vld   = ext_own || dmac_own;
        bus_addr  = dmac_own ? dmac_addr  : addr;
        bus_rw    = dmac_own ? dmac_rw    : rw_;
        bus_wdata = dmac_own ? dmac_wdata : idata;
    end

    assign ofs    = bus_addr[7:0];
    assign bus_we = bus_vld && (bus_rw == Write) && !reset_;

    always_comb begin
        cs0_ = Disable_;
        cs1_ = Disable_;
        cs2_ = Disable_;
        if (bus_vld) begin
            case (bus_addr[9:8])
                REGION_RAM0:  cs0_ = Enable_;
                REGION_RAM1:  cs1_ = Enable_;
                REGION_TIMER: cs2_ = Enable_;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (bus_we && cs0_ == Enable_) ram0_q[ofs] <= bus_wdata;
        if (bus_we && cs1_ == Enable_) ram1_q[ofs] <= bus_wdata;
    end

    always_comb begin
        bus_rdata = '0;
        if (cs0_ == Enable_)      bus_rdata = ram0_q[ofs];
        else if (cs1_ == Enable_) bus_rdata = ram1_q[ofs];
        else if (cs2_ == Enable_ && ofs == TMR_COUNT_OFS) bus_rdata = count_q;
    end

    assign odata = (ext_own && rw_ == Read) ? bus_rdata : '0;

    assign tmr_wr = bus_we && (cs2_ == Enable_) && (ofs == TMR_CTRL_OFS);

    // Clear wins over counting in the same cycle; stop wins over start
    always_comb begin
        count_d = count_q;
        run_d   = run_q;
        if (tmr_wr && bus_wdata[TMR_CLR_BIT]) count_d = '0;
        else if (run_q)                       count_d = count_q + 1'b1;
        if (tmr_wr) begin
            if (bus_wdata[TMR_STOP_BIT])       run_d = 1'b0;
            else if (bus_wdata[TMR_START_BIT]) run_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_) begin
            count_q <= '0;
            run_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: tb/tb_dma_bus_system.sv
// Randomized and directed bench for dma_bus_system against a transaction-timeline reference model.
module tb_dma_bus_system;

    logic       clk = 1'b0;
    logic       reset_ = 1'b1;
    logic [9:0] addr = '0, dsaddr = '0, ddaddr = '0;
    logic [7:0] idata = '0;
    logic [7:0] odata;
    logic       rw_ = 1'b1, breq_ = 1'b0, dreq_ = 1'b1;
    logic [1:0] dmode = '0;
    logic       bgrt_, eop_;

    dma_bus_system dut (
        .clk(clk), .reset_(reset_), .addr(addr), .idata(idata), .odata(odata),
        .rw_(rw_), .breq_(breq_), .bgrt_(bgrt_), .dsaddr(dsaddr), .ddaddr(ddaddr),
        .dmode(dmode), .dreq_(dreq_), .eop_(eop_)
    );

    always #5 clk = ~clk;

    int ntests = 0, nfail = 0, eop_lows = 0;

    // Reference model: memory image, timer, and DMA progress as edges elapsed since the dreq_ sample
    logic [7:0] mem [512];
    logic [7:0] tcnt = '0;
    bit         trun = 0;
    int         busy = 0, blen = 1;
    logic [9:0] bs, bd;
    logic [7:0] bhold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mread(input logic [9:0] a);
        case (a[9:8])
            2'b00, 2'b01: return mem[a[8:0]];
            2'b10:        return (a[7:0] == 8'h00) ? tcnt : 8'h00;
            default:      return 8'h00;
        endcase
    endfunction

    function automatic bit granted();
        return (breq_ == 1'b0) && (busy == 0);
    endfunction

    // Byte j is read 2j+1 edges after the sample and written 2j+2 edges after; EOP follows the last write
    function automatic void mstep();
        bit w = 0, tw = 0;
        logic [9:0] wa = '0;
        logic [7:0] wd = '0, twd = '0;
        int j;
        if (reset_) begin
            busy = 0; tcnt = '0; trun = 0;
            return;
        end
        if (granted() && rw_ == 1'b0) begin
            w = 1; wa = addr; wd = idata;
        end
        if (busy > 0 && busy <= 2 * blen) begin
            j = (busy - 1) / 2;
            if (busy % 2 == 1) bhold = mread(bs + 10'(j));
            else begin w = 1; wa = bd + 10'(j); wd = bhold; end
        end
        if (w) begin
            if (wa[9] == 1'b0) mem[wa[8:0]] = wd;
            else if (wa[8] == 1'b0 && wa[7:0] == 8'h04) begin tw = 1; twd = wd; end
        end
        if (tw && twd[0]) tcnt = '0;
        else if (trun) tcnt = tcnt + 8'd1;
        if (tw) begin
            if (twd[2]) trun = 0;
            else if (twd[1]) trun = 1;
        end
        if (busy == 0) begin
            if (dreq_ == 1'b0 && breq_ == 1'b1) begin
                busy = 1; bs = dsaddr; bd = ddaddr;
                blen = (dmode == 2'd1) ? 4 : 1;
            end
        end else if (busy == 2 * blen + 1) busy = 0;
        else busy++;
    endfunction

    // One clock: check outputs against the model, then advance both across the edge
    task automatic cyc();
        #1;
        if (!reset_) begin
            chk("bgrt_", bgrt_, granted() ? 1'b0 : 1'b1);
            chk("eop_", eop_, (busy == 2 * blen + 1) ? 1'b0 : 1'b1);
            chk("odata", odata, (granted() && rw_) ? mread(addr) : 8'h00);
            if (eop_ == 1'b0) eop_lows++;
        end
        @(posedge clk);
        mstep();
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [7:0] d);
        breq_ = 1'b0; rw_ = 1'b0; addr = a; idata = d;
        cyc();
        rw_ = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [9:0] a, input logic [7:0] exp);
        breq_ = 1'b0; rw_ = 1'b1; addr = a;
        #1;
        chk(tag, odata, exp);
        cyc();
    endtask

    task automatic dma(input logic [9:0] s, input logic [9:0] d, input logic [1:0] m);
        breq_ = 1'b1; dreq_ = 1'b0; dsaddr = s; ddaddr = d; dmode = m;
        cyc();
        dreq_ = 1'b1;
    endtask

    logic [7:0] t1, t2, pre2, pre3;

    initial begin
        repeat (2) cyc();
        reset_ = 1'b0;
        #1;
        chk("rst_eop", eop_, 1'b1);
        chk("rst_bgrt", bgrt_, 1'b0);
        rd_chk("rst_tmr", 10'h200, 8'h00);

        for (int i = 0; i < 512; i++) wr(10'(i), 8'($urandom));

        wr(10'h120, 8'h99);
        rd_chk("rd_120", 10'h120, 8'h99);
        wr(10'h019, 8'hF5);
        rd_chk("rd_019", 10'h019, 8'hF5);
        rd_chk("rd_unmapped", 10'h3A5, 8'h00);

        wr(10'h204, 8'h04);
        wr(10'h204, 8'h01);
        wr(10'h204, 8'h02);
        breq_ = 1'b1;
        repeat (50) cyc();
        breq_ = 1'b0; rw_ = 1'b1; addr = 10'h200;
        #1; t1 = odata;
        cyc();
        breq_ = 1'b1;
        repeat (50) cyc();
        breq_ = 1'b0; addr = 10'h200;
        #1; t2 = odata;
        chk("tmr_delta", 8'(t2 - t1), 8'd51);
        cyc();

        eop_lows = 0;
        dma(10'h019, 10'h150, 2'd0);
        repeat (6) cyc();
        chk("single_eop_width", eop_lows, 1);
        rd_chk("single_dst", 10'h150, 8'hF5);

        for (int i = 0; i < 4; i++) wr(10'h090 + 10'(i), 8'h50 + 8'(i));
        eop_lows = 0;
        dma(10'h090, 10'h120, 2'd1);
        repeat (10) cyc();
        chk("burst_eop_width", eop_lows, 1);
        for (int i = 0; i < 4; i++) rd_chk("burst_dst", 10'h120 + 10'(i), 8'h50 + 8'(i));

        // External master requests and attempts writes mid-burst
        dma(10'h090, 10'h1A0, 2'd1);
        cyc();
        breq_ = 1'b0; rw_ = 1'b0; addr = 10'h1A2; idata = 8'hEE;
        repeat (7) cyc();
        rw_ = 1'b1;
        #1;
        chk("arb_hold_in_eop", {bgrt_, eop_}, 2'b10);
        cyc();
        #1;
        chk("arb_grant_after", bgrt_, 1'b0);
        rd_chk("arb_no_ext_wr", 10'h1A2, 8'h52);

        pre2 = mem[9'h1C2]; pre3 = mem[9'h1C3];
        dma(10'h090, 10'h1C0, 2'd1);
        repeat (4) cyc();
        reset_ = 1'b1;
        repeat (2) cyc();
        reset_ = 1'b0;
        breq_ = 1'b1;
        #1;
        chk("rstmid_eop", eop_, 1'b1);
        rd_chk("rstmid_tmr", 10'h200, 8'h00);
        rd_chk("rstmid_b0", 10'h1C0, 8'h50);
        rd_chk("rstmid_b1", 10'h1C1, 8'h51);
        rd_chk("rstmid_b2", 10'h1C2, pre2);
        rd_chk("rstmid_b3", 10'h1C3, pre3);

        for (int n = 0; n < 800; n++) begin
            breq_  = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            dreq_  = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
            dmode  = 2'($urandom_range(0, 3));
            dsaddr = 10'($urandom);
            ddaddr = 10'($urandom);
            addr   = 10'($urandom);
            idata  = 8'($urandom);
            rw_    = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            cyc();
        end
        dreq_ = 1'b1; breq_ = 1'b1; rw_ = 1'b1;
        repeat (12) cyc();
        for (int i = 0; i < 512; i += 37) rd_chk("final_mem", 10'(i), mem[i]);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
